// File: rtl/wave_play_ctrl.sv
// wave_play_ctrl -- playback controller for the waveform sample ROM.
//
// Walks the ROM address with a programmable stride, paces address updates
// with a clock divider, counts completed waveform periods (address wraps)
// and pushes the ROM word MSBs onto the 8-bit DAC output through a 2-stage
// valid pipe that matches the one-clock ROM read latency.
//
// Build option: define WAVE_PLAY_HOLD_EN to make odata keep its last loaded
// sample when playback stops or completes. Without it, odata returns to the
// DAC mid-scale code 8'h80 whenever the player drops back to IDLE.
module wave_play_ctrl #(
  parameter int DEPTH  = 1000,
  parameter int AW     = 10,
  parameter int DW     = 16,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [STEP_W-1:0] step,
  input  logic [15:0]       div,
  input  logic [15:0]       cycles,
  output logic [AW-1:0]     rom_addr,
  input  logic [DW-1:0]     rom_data,
  output logic [7:0]        odata,
  output logic              busy,
  output logic              done
);

  // The address sum needs one extra bit so rom_addr + step never overflows
  // before it is compared against DEPTH.
  localparam int               SUM_W      = AW + 1;
  localparam logic [SUM_W-1:0] DEPTH_S    = SUM_W'(DEPTH);
  localparam logic [7:0]       ODATA_IDLE = 8'h80;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Playback parameters captured when start is accepted.
  logic [STEP_W-1:0] step_q;
  logic [15:0]       div_q;
  logic [15:0]       cycles_q;

  // Running counters.
  logic [15:0]       div_cnt;
  logic [15:0]       period_cnt;

  // Sample valid pipe: stage 1 = address just issued, stage 2 = ROM data ready.
  logic              smp_v1;
  logic              smp_v2;

  // Decoded events for the current cycle.
  logic              accept;
  logic              abort;
  logic              tick;
  logic              wrap;
  logic              complete;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_mod;
  logic [AW-1:0]     next_addr;
  logic [15:0]       period_inc;

  // Decode start/stop/tick/wrap/completion events from the current state.
  always_comb begin
    // NOTE: every signal driven here is assigned on every path through the
    // block; a path that skipped one would silently infer a latch.
    accept     = (state_q == IDLE) && start && !stop;
    abort      = (state_q == RUN) && stop;
    tick       = (state_q == RUN) && (div_cnt == 16'd0);
    sum        = SUM_W'(rom_addr) + SUM_W'(step_q);
    wrap       = tick && (sum >= DEPTH_S);
    sum_mod    = wrap ? (sum - DEPTH_S) : sum;
    next_addr  = sum_mod[AW-1:0];
    period_inc = period_cnt + 16'd1;
    // A zero cycle count means continuous play, so it never completes.
    complete   = wrap && (cycles_q != 16'd0) && (period_inc == cycles_q);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stop beats start in IDLE and beats completion in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort || complete) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    busy = (state_q == RUN);
  end

  // Address generator, divider, period counter, sample pipe and DAC register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this block holds only a handful of control registers (no memory
    // arrays), so all of it is cleared by reset to give a known power-up
    // state on rom_addr and the DAC.
    if (!rst_n) begin
      rom_addr   <= '0;
      odata      <= ODATA_IDLE;
      done       <= 1'b0;
      smp_v1     <= 1'b0;
      smp_v2     <= 1'b0;
      step_q     <= '0;
      div_q      <= '0;
      cycles_q   <= '0;
      div_cnt    <= '0;
      period_cnt <= '0;
    end else begin
      // Default pipe advance; overridden below by new strobes and flushes.
      done   <= 1'b0;
      smp_v1 <= 1'b0;
      smp_v2 <= smp_v1;
      if (smp_v2) begin
        odata <= rom_data[DW-1 -: 8];
      end

      if (accept) begin
        // Latch parameters and issue the strobe for address 0.
        step_q     <= step;
        div_q      <= div;
        cycles_q   <= cycles;
        div_cnt    <= div;
        period_cnt <= '0;
        rom_addr   <= '0;
        smp_v1     <= 1'b1;
      end else if (abort) begin
        // Abort: flush in-flight samples so none of them reaches odata.
        rom_addr <= '0;
        smp_v1   <= 1'b0;
        smp_v2   <= 1'b0;
`ifdef WAVE_PLAY_HOLD_EN
        odata    <= odata;
`else
        odata    <= ODATA_IDLE;
`endif
      end else if (state_q == RUN) begin
        div_cnt <= (div_cnt == 16'd0) ? div_q : (div_cnt - 16'd1);
        if (tick) begin
          if (wrap) begin
            period_cnt <= period_inc;
          end
          if (complete) begin
            // Natural end: no strobe for this tick, pending samples dropped.
            rom_addr <= '0;
            done     <= 1'b1;
            smp_v1   <= 1'b0;
            smp_v2   <= 1'b0;
`ifdef WAVE_PLAY_HOLD_EN
            odata    <= odata;
`else
            odata    <= ODATA_IDLE;
`endif
          end else begin
            rom_addr <= next_addr;
            smp_v1   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_play_ctrl.sv
// tb_wave_play_ctrl -- self-checking bench for wave_play_ctrl.
// A synchronous ROM model returns mem[i] = {i[7:0], 8'h00} one clock after
// the address. Expected behaviour is computed arithmetically: tick k lands
// on clock k*(div+1) after the start edge, the address there is
// (k*step) mod DEPTH, and completion happens on the first tick whose
// cumulative wrap count floor(k*step/DEPTH) reaches cycles.
module tb_wave_play_ctrl;

  localparam int DEPTH  = 1000;
  localparam int AW     = 10;
  localparam int DW     = 16;
  localparam int STEP_W = 8;

`ifdef WAVE_PLAY_HOLD_EN
  localparam logic [7:0] IDLE_OD = 8'h00;
  localparam bit         HOLD    = 1'b1;
`else
  localparam logic [7:0] IDLE_OD = 8'h80;
  localparam bit         HOLD    = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic [STEP_W-1:0] step;
  logic [15:0]       div;
  logic [15:0]       cycles;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data;
  logic [7:0]        odata;
  logic              busy;
  logic              done;

  int                n_vec  = 0;
  int                n_miss = 0;
  logic [7:0]        exp_od;

  wave_play_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .STEP_W(STEP_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .step    (step),
    .div     (div),
    .cycles  (cycles),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .odata   (odata),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous sample ROM.
  always @(posedge clk) begin
    rom_data <= {rom_addr[7:0], 8'h00};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_odata"}, 32'(odata), 32'(exp_od));
  endtask

  // One playback run: start with (s,d,c), follow for up to len clocks while
  // scrambling don't-care inputs and throwing ignored start pulses, then
  // abort with stop if it has not completed by itself.
  task automatic run_trial(input int s, input int d, input int c, input int len);
    bit has_c;
    bit finished;
    int nc;
    int k;
    int exp_addr;
    has_c    = (c != 0) && (s != 0);
    nc       = has_c ? ((c * DEPTH + s - 1) / s) * (d + 1) : 0;
    finished = 1'b0;

    step   = 8'(s);
    div    = 16'(d);
    cycles = 16'(c);
    start  = 1'b1;
    stop   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_addr", 32'(rom_addr), 32'd0);
    check("start_done", 32'(done), 32'd0);
    check("start_odata", 32'(odata), 32'(exp_od));

    for (int n = 1; n <= len; n++) begin
      step   = 8'($urandom);
      div    = 16'($urandom);
      cycles = 16'($urandom);
      start  = (!has_c || n <= nc) && ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
      start = 1'b0;
      if (has_c && n == nc) begin
        if (!HOLD) exp_od = 8'h80;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_addr", 32'(rom_addr), 32'd0);
        check("done_odata", 32'(odata), 32'(exp_od));
      end else if (has_c && n == nc + 1) begin
        check_idle("after_done");
        finished = 1'b1;
        break;
      end else begin
        k        = n / (d + 1);
        exp_addr = (k * s) % DEPTH;
        if (n >= 2) exp_od = 8'((((n - 2) / (d + 1)) * s) % DEPTH);
        check("run_addr", 32'(rom_addr), 32'(exp_addr));
        check("run_busy", 32'(busy), 32'd1);
        check("run_done", 32'(done), 32'd0);
        check("run_odata", 32'(odata), 32'(exp_od));
      end
    end

    if (!finished) begin
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      if (!HOLD) exp_od = 8'h80;
      check_idle("stop");
      repeat (3) begin
        @(posedge clk); #1;
        check_idle("stop_flush");
      end
    end
  endtask

  typedef struct {
    logic        start;
    logic        stop;
    logic [7:0]  step;
    logic [15:0] div;
    logic [15:0] cycles;
    logic [9:0]  e_addr;
    logic        e_busy;
    logic        e_done;
    logic [7:0]  e_od;
  } vec_t;

  vec_t tbl [8];

  initial begin
    // start, stop, step, div, cycles -> addr, busy, done, odata (one row per clock)
    tbl[0] = '{1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 10'd0, 1'b0, 1'b0, 8'h80};  // idle
    tbl[1] = '{1'b1, 1'b1, 8'd1, 16'd0, 16'd0, 10'd0, 1'b0, 1'b0, 8'h80};  // start+stop: stay idle
    tbl[2] = '{1'b1, 1'b0, 8'd1, 16'd0, 16'd0, 10'd0, 1'b1, 1'b0, 8'h80};  // start accepted
    tbl[3] = '{1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 10'd1, 1'b1, 1'b0, 8'h80};  // first tick
    tbl[4] = '{1'b1, 1'b0, 8'd9, 16'd5, 16'd7, 10'd2, 1'b1, 1'b0, 8'h00};  // start in RUN ignored
    tbl[5] = '{1'b0, 1'b1, 8'd0, 16'd0, 16'd0, 10'd0, 1'b0, 1'b0, IDLE_OD}; // stop: sample 1 dropped
    tbl[6] = '{1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 10'd0, 1'b0, 1'b0, IDLE_OD};
    tbl[7] = '{1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 10'd0, 1'b0, 1'b0, IDLE_OD};

    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    step   = '0;
    div    = '0;
    cycles = '0;
    exp_od = 8'h80;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state held through 20 idle clocks.
    repeat (20) @(posedge clk);
    #1;
    check_idle("reset_idle");

    // Table-driven short sequence.
    for (int i = 0; i < 8; i++) begin
      start  = tbl[i].start;
      stop   = tbl[i].stop;
      step   = tbl[i].step;
      div    = tbl[i].div;
      cycles = tbl[i].cycles;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_addr", i), 32'(rom_addr), 32'(tbl[i].e_addr));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      check($sformatf("tbl%0d_odata", i), 32'(odata), 32'(tbl[i].e_od));
    end
    start  = 1'b0;
    stop   = 1'b0;
    exp_od = IDLE_OD;

    // Multi-cycle corners.
    run_trial(1, 0, 0, 1010);   // full-rate, wrap 999->0, no done
    run_trial(100, 3, 2, 100);  // done on the 20th tick
    run_trial(7, 0, 0, 150);    // wrap 994->1
    run_trial(7, 0, 1, 160);    // that wrap alone completes one period
    run_trial(0, 0, 1, 30);     // zero stride never completes

    // Randomized runs.
    for (int t = 0; t < 20; t++) begin
      int s;
      s = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      run_trial(s, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                int'($urandom_range(5, 400)));
    end

    // Asynchronous reset in the middle of playback.
    step   = 8'd3;
    div    = 16'd1;
    cycles = 16'd0;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    exp_od = 8'h80;
    check_idle("async_rst");
    @(posedge clk); #1;
    check_idle("async_rst_hold");
    rst_n = 1'b1;

    // Recovery after reset, ending in completion.
    run_trial(5, 1, 1, 450);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
